// File: rtl/soc_disp_pkg.sv
// Purpose: shared types and constants for the SOC-to-BCD display path.
// Contents: FSM state enum, BCD accumulator struct, percentage/display limits.
package soc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCALE = 2'd1,
        CONV  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Three-digit BCD accumulator used during double-dabble.
    typedef struct packed {
        logic [3:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    localparam logic [6:0]  PCT_MAX    = 7'd100;
    localparam logic [7:0]  BCD_FULL   = 8'hA0;
    localparam int unsigned CONV_STEPS = 7;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned BIN_W      = 7;

endpackage : soc_disp_pkg

// File: rtl/bcd_add3.sv
// Purpose: double-dabble nibble correction, adds 3 to any digit >= 5.
// Ports:
//   nib_i  - BCD digit before correction
//   adj_c  - corrected digit (combinational)
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] adj_c
);

    always_comb begin
        adj_c = nib_i;
        if (nib_i >= 4'd5) begin
            adj_c = nib_i + 4'd3;
        end
    end

endmodule : bcd_add3

// File: rtl/soc_to_bcd.sv
// Purpose: converts an unsigned fixed-point SOC fraction into a 2-digit
//          display code {tens, ones}; 100 % is shown as 8'hA0.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   soc_q      - SOC estimate, Q(IN_W-FRAC_W).FRAC_W
//   in_valid   - soc_q valid this cycle
//   in_ready   - block can accept (high only while idle)
//   soc_int    - registered BCD display code
//   soc_valid  - one-cycle pulse when soc_int has just been updated
//   sat        - registered, 1 if the pre-clamp percentage exceeded 100
module soc_to_bcd
    import soc_disp_pkg::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned FRAC_W = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] soc_q,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [7:0]      soc_int,
    output logic            soc_valid,
    output logic            sat
);

    localparam int unsigned PROD_W = IN_W + 7;
    localparam int unsigned PCT_W  = PROD_W - FRAC_W;
    localparam logic [PROD_W-1:0] ROUND_ADD = PROD_W'(1) << (FRAC_W - 1);

    state_e            state_q, state_d;
    logic [IN_W-1:0]   cap_q, cap_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    bcd_t              bcd_q, bcd_d;
    bcd_t              bcd_adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_next_q, sat_next_d;
    logic [7:0]        soc_int_q, soc_int_d;
    logic              sat_q, sat_d;
    logic              soc_valid_q, soc_valid_d;
    logic              in_ready_q, in_ready_d;

    logic [PROD_W-1:0] prod;
    logic [PCT_W-1:0]  pct_raw;
    logic              over;

    // Per-digit correction applied before every shift of the conversion.
    bcd_add3 u_add3_hund (.nib_i(bcd_q.hund), .adj_c(bcd_adj.hund));
    bcd_add3 u_add3_tens (.nib_i(bcd_q.tens), .adj_c(bcd_adj.tens));
    bcd_add3 u_add3_ones (.nib_i(bcd_q.ones), .adj_c(bcd_adj.ones));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            sat_next_q  <= 1'b0;
            soc_int_q   <= 8'h00;
            sat_q       <= 1'b0;
            soc_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            sat_next_q  <= sat_next_d;
            soc_int_q   <= soc_int_d;
            sat_q       <= sat_d;
            soc_valid_q <= soc_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next-state, scaling and conversion steps.
    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        sat_next_d  = sat_next_q;
        soc_int_d   = soc_int_q;
        sat_d       = sat_q;
        soc_valid_d = 1'b0;

        // Rounded percentage: (x*100 + 0.5 LSB of the percent) >> FRAC_W.
        prod    = PROD_W'(cap_q) * PROD_W'(PCT_MAX) + ROUND_ADD;
        pct_raw = PCT_W'(prod >> FRAC_W);
        over    = (pct_raw > PCT_W'(PCT_MAX));

        unique case (state_q)
            IDLE: begin
                // in_ready is high whenever the FSM sits in IDLE.
                if (in_valid) begin
                    cap_d   = soc_q;
                    state_d = SCALE;
                end
            end
            SCALE: begin
                bin_d      = over ? PCT_MAX : pct_raw[BIN_W-1:0];
                bcd_d      = '0;
                cnt_d      = '0;
                sat_next_d = over;
                state_d    = CONV;
            end
            CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CONV_STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Clamped input keeps hundreds at 0 or 1; 1 means exactly 100.
                soc_int_d   = (bcd_q.hund != 4'd0) ? BCD_FULL
                                                   : {bcd_q.tens, bcd_q.ones};
                sat_d       = sat_next_q;
                soc_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    assign in_ready  = in_ready_q;
    assign soc_int   = soc_int_q;
    assign soc_valid = soc_valid_q;
    assign sat       = sat_q;

endmodule : soc_to_bcd
